// File: rtl/filter_driver_if.sv
// Bus between filter_driver and its environment: upstream coefficient stream,
// sample tick/result side, and the filter's load/clear/start port.
interface filter_driver_if #(
    parameter int unsigned W = 16
);
    logic [9:0]   cin_data;
    logic         cin_valid;
    logic         cin_ready;
    logic         tick;
    logic [W-1:0] src_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         overrun;
    logic [9:0]   f_coef;
    logic         f_coef_load;
    logic         f_clear;
    logic [W-1:0] f_sig;
    logic         f_start;
    logic         f_done;
    logic [W-1:0] f_sig_out;

    modport master (
        input  cin_data, cin_valid, tick, src_in, f_done, f_sig_out,
        output cin_ready, out_data, out_valid, overrun,
               f_coef, f_coef_load, f_clear, f_sig, f_start
    );

    modport slave (
        output cin_data, cin_valid, tick, src_in, f_done, f_sig_out,
        input  cin_ready, out_data, out_valid, overrun,
               f_coef, f_coef_load, f_clear, f_sig, f_start
    );
endinterface

// File: rtl/filter_driver.sv
// Host-side sequencer for the all-pole filter: buffers coefficient frames,
// shifts them into the filter, and runs one filter pass per sample tick.
// Optional FILTER_DRIVER_CLEAR_EN adds a filter-state clear after each frame.
module filter_driver #(
    parameter int unsigned NCOEF = 12,
    parameter int unsigned W     = 16
) (
    input  logic            clk,
    input  logic            rst_an,
    filter_driver_if.master bus
);
    localparam int unsigned     KW   = $clog2(NCOEF + 1);
    localparam logic [KW-1:0]   LAST = KW'(NCOEF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef FILTER_DRIVER_CLEAR_EN
        S_CLEAR,
`endif
        S_START,
        S_WAIT1,
        S_BUSY
    } state_t;

    state_t        r_state;
    logic [9:0]    r_shadow [NCOEF];
    logic [KW-1:0] r_widx;
    logic [KW-1:0] r_k;
    logic          r_frame_full;
    logic          r_pend;
    logic [W-1:0]  r_samp;
    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_overrun;
    logic [9:0]    r_f_coef;
    logic          r_f_coef_load;
    logic [W-1:0]  r_f_sig;
    logic          r_f_start;
`ifdef FILTER_DRIVER_CLEAR_EN
    logic          r_f_clear;
`endif

    logic w_cin_fire;
    logic w_load_end;
    logic w_commit;
    logic w_consume;

    // LOAD hands off one edge early so the last beat overlaps the following
    // state; the beat itself ends (and the frame is released) on w_load_end.
    assign w_cin_fire = bus.cin_valid && !r_frame_full;
    assign w_load_end = r_f_coef_load && (r_state != S_LOAD);
    assign w_commit   = (r_state == S_IDLE) && bus.f_done && r_frame_full && !r_f_coef_load;
    assign w_consume  = (r_state == S_IDLE) && bus.f_done && !w_commit && r_pend;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            r_state       <= S_IDLE;
            for (int unsigned i = 0; i < NCOEF; i++) r_shadow[i] <= '0;
            r_widx        <= '0;
            r_k           <= '0;
            r_frame_full  <= 1'b0;
            r_pend        <= 1'b0;
            r_samp        <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_f_coef      <= '0;
            r_f_coef_load <= 1'b0;
            r_f_sig       <= '0;
            r_f_start     <= 1'b0;
`ifdef FILTER_DRIVER_CLEAR_EN
            r_f_clear     <= 1'b0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_f_start   <= 1'b0;
`ifdef FILTER_DRIVER_CLEAR_EN
            r_f_clear   <= 1'b0;
`endif
            if (w_cin_fire) begin
                r_shadow[r_widx] <= bus.cin_data;
                r_widx           <= r_widx + 1'b1;
                if (r_widx == LAST) r_frame_full <= 1'b1;
            end
            if (w_load_end) begin
                r_f_coef_load <= 1'b0;
                r_frame_full  <= 1'b0;
                r_widx        <= '0;
            end

            // A tick in the consuming cycle re-arms pend without overrun.
            if (bus.tick) begin
                r_samp <= bus.src_in;
                r_pend <= 1'b1;
                if (r_pend && !w_consume) r_overrun <= 1'b1;
            end else if (w_consume) begin
                r_pend <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_commit) begin
                        r_state       <= S_LOAD;
                        r_f_coef_load <= 1'b1;
                        r_f_coef      <= r_shadow[0];
                        r_k           <= KW'(1);
                    end else if (w_consume) begin
                        r_state   <= S_START;
                        r_f_start <= 1'b1;
                        r_f_sig   <= r_samp;
                    end
                end
                S_LOAD: begin
                    r_f_coef <= r_shadow[r_k];
                    r_k      <= r_k + 1'b1;
                    if (r_k == LAST) begin
`ifdef FILTER_DRIVER_CLEAR_EN
                        r_state <= S_CLEAR;
`else
                        r_state <= S_IDLE;
`endif
                    end
                end
`ifdef FILTER_DRIVER_CLEAR_EN
                S_CLEAR: begin
                    r_f_clear <= 1'b1;
                    r_state   <= S_IDLE;
                end
`endif
                S_START: r_state <= S_WAIT1;
                S_WAIT1: r_state <= S_BUSY;
                S_BUSY: begin
                    if (bus.f_done) begin
                        r_out_data  <= bus.f_sig_out;
                        r_out_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cin_ready   = !r_frame_full;
    assign bus.out_data    = r_out_data;
    assign bus.out_valid   = r_out_valid;
    assign bus.overrun     = r_overrun;
    assign bus.f_coef      = r_f_coef;
    assign bus.f_coef_load = r_f_coef_load;
    assign bus.f_sig       = r_f_sig;
    assign bus.f_start     = r_f_start;
`ifdef FILTER_DRIVER_CLEAR_EN
    assign bus.f_clear     = r_f_clear;
`else
    assign bus.f_clear     = 1'b0;
`endif
endmodule

// File: tb/tb_filter_driver.sv
// Scoreboard bench for filter_driver with a behavioural pass-through filter.
module tb_filter_driver;
    localparam int NCOEF = 12;
`ifdef FILTER_DRIVER_CLEAR_EN
    localparam int CLR_EXTRA = 1;
    localparam int EXP_CLR   = 3;
`else
    localparam int CLR_EXTRA = 0;
    localparam int EXP_CLR   = 0;
`endif

    logic clk;
    logic rst_an;
    int   cyc;
    int   n_tests;
    int   n_fail;

    filter_driver_if #(.W(16)) bus ();

    filter_driver #(.NCOEF(NCOEF), .W(16)) dut (
        .clk    (clk),
        .rst_an (rst_an),
        .bus    (bus)
    );

    logic [9:0]  coef_q[$];
    logic [15:0] start_sig_q[$];
    int          start_cyc_q[$];
    logic [15:0] out_q[$];
    int load_cnt, load_run, last_run, clr_cnt, ovr_cnt, ov_cnt;
    logic prev_load, prev_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Filter model: done drops after start, result = held f_sig (a=0 case).
    int f_cnt;
    always @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            bus.f_done    <= 1'b1;
            bus.f_sig_out <= '0;
            f_cnt         <= 0;
        end else if (bus.f_start) begin
            bus.f_done <= 1'b0;
            f_cnt      <= 6;
        end else if (!bus.f_done) begin
            if (f_cnt == 0) begin
                bus.f_done    <= 1'b1;
                bus.f_sig_out <= bus.f_sig;
            end else begin
                f_cnt <= f_cnt - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s got=%0h required=nothing (cycle %0d)", name, act, cyc);
    endtask

    // Monitor
    initial begin
        prev_load = 1'b0;
        prev_done = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_an) begin
                if (bus.f_coef_load) begin
                    load_cnt++;
                    load_run++;
                    check("load_filter_idle", bus.f_done, 1);
                    check("ready_low_in_load", bus.cin_ready, 0);
                    if (coef_q.size() == 0) extra("coef_extra", bus.f_coef);
                    else check("coef", bus.f_coef, coef_q.pop_front());
                end else if (prev_load) begin
                    last_run = load_run;
                    load_run = 0;
                    check("ready_after_load", bus.cin_ready, 1);
                end
                if (bus.f_start) begin
                    check("start_filter_idle", bus.f_done, 1);
                    check("start_not_load", bus.f_coef_load, 0);
                    check("start_after_frame", coef_q.size(), 0);
                    if (start_sig_q.size() == 0) extra("start_extra", bus.f_sig);
                    else begin
                        int ec;
                        check("f_sig", bus.f_sig, start_sig_q.pop_front());
                        ec = start_cyc_q.pop_front();
                        if (ec >= 0) check("start_latency", cyc, ec);
                    end
                end
                if (bus.f_clear) begin
                    clr_cnt++;
                    check("clear_after_last_beat", {prev_load, bus.f_coef_load}, 2'b10);
                end
                if (bus.overrun) ovr_cnt++;
                if (bus.out_valid) begin
                    ov_cnt++;
                    check("valid_after_done", prev_done, 1);
                    if (out_q.size() == 0) extra("out_extra", bus.out_data);
                    else check("out_data", bus.out_data, out_q.pop_front());
                end
                prev_load = bus.f_coef_load;
                prev_done = bus.f_done;
            end else begin
                prev_load = 1'b0;
                prev_done = 1'b1;
                load_run  = 0;
            end
        end
    end

    task automatic send_word(input logic [9:0] w);
        bus.cin_data  = w;
        bus.cin_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (bus.cin_ready) begin
                @(negedge clk);
                bus.cin_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.cin_valid = 1'b0;
        check("send_word_timeout", 0, 1);
    endtask

    task automatic send_frame(input logic [9:0] base, input logic [9:0] step);
        for (int i = 0; i < NCOEF; i++) begin
            coef_q.push_back(base + 10'(i) * step);
            send_word(base + 10'(i) * step);
        end
    endtask

    task automatic do_tick(input logic [15:0] s);
        bus.tick   = 1'b1;
        bus.src_in = s;
        @(negedge clk);
        bus.tick   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((coef_q.size() + start_sig_q.size() + out_q.size()) != 0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check(name, coef_q.size() + start_sig_q.size() + out_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cin_ready"}, bus.cin_ready, 1);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
        check({tag, "_f_coef"}, bus.f_coef, 0);
        check({tag, "_f_coef_load"}, bus.f_coef_load, 0);
        check({tag, "_f_clear"}, bus.f_clear, 0);
        check({tag, "_f_sig"}, bus.f_sig, 0);
        check({tag, "_f_start"}, bus.f_start, 0);
        check({tag, "_widx"}, dut.r_widx, 0);
    endtask

    initial begin
        int t;
        int base_ov;
        int base_load;
        n_tests = 0; n_fail = 0; cyc = 0;
        load_cnt = 0; load_run = 0; last_run = 0;
        clr_cnt = 0; ovr_cnt = 0; ov_cnt = 0;
        rst_an = 1'b0;
        bus.cin_data = '0; bus.cin_valid = 1'b0;
        bus.tick = 1'b0; bus.src_in = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_an = 1'b1;
        @(negedge clk);

        // Frame 0x001..0x00C loads in order, ready drops then returns
        send_frame(10'h001, 10'h001);
        check("ready_low_when_full", bus.cin_ready, 0);
        wait_drain("frame1_drain");
        check("load_run_len", last_run, NCOEF);
        check("ready_high_after_frame", bus.cin_ready, 1);

        // Zero frame, then one sample through the pass-through filter
        send_frame(10'h000, 10'h000);
        wait_drain("frame0_drain");
        t = cyc;
        start_sig_q.push_back(16'h1234); start_cyc_q.push_back(t + 2);
        out_q.push_back(16'h1234);
        do_tick(16'h1234);
        wait_drain("tick_drain");
        check("ov_after_tick", ov_cnt, 1);

        // Two ticks while busy: one overrun, newest sample processed next
        base_ov = ov_cnt;
        start_sig_q.push_back(16'h1111); start_cyc_q.push_back(cyc + 2);
        start_sig_q.push_back(16'h3333); start_cyc_q.push_back(-1);
        out_q.push_back(16'h1111); out_q.push_back(16'h3333);
        do_tick(16'h1111);
        for (int c = 0; c < 20 && bus.f_done; c++) @(negedge clk);
        check("filter_went_busy", bus.f_done, 0);
        bus.tick = 1'b1; bus.src_in = 16'h2222;
        @(negedge clk);
        bus.src_in = 16'h3333;
        @(negedge clk);
        bus.tick = 1'b0;
        wait_drain("overrun_drain");
        check("overrun_count", ovr_cnt, 1);
        check("two_results", ov_cnt - base_ov, 2);

        // Frame completes on the same cycle as a tick: LOAD first, then START
        for (int i = 0; i < NCOEF - 1; i++) begin
            coef_q.push_back(10'h3F0 + 10'(i));
            send_word(10'h3F0 + 10'(i));
        end
        coef_q.push_back(10'h3FB);
        t = cyc;
        start_sig_q.push_back(16'h4444); start_cyc_q.push_back(t + 2 + NCOEF + CLR_EXTRA);
        out_q.push_back(16'h4444);
        bus.cin_data = 10'h3FB; bus.cin_valid = 1'b1;
        bus.tick = 1'b1; bus.src_in = 16'h4444;
        @(negedge clk);
        bus.cin_valid = 1'b0; bus.tick = 1'b0;
        wait_drain("commit_tick_drain");

        // Asynchronous reset during beat 5 of LOAD
        for (int i = 0; i < 6; i++) coef_q.push_back(10'h200 + 10'(i));
        base_load = load_cnt;
        for (int i = 0; i < NCOEF; i++) send_word(10'h200 + 10'(i));
        for (int c = 0; c < 40 && load_cnt != base_load + 6; c++) begin
            @(negedge clk);
            #1;
        end
        check("reached_beat5", load_cnt - base_load, 6);
        rst_an = 1'b0;
        #1;
        check_reset_state("midload_reset");
        repeat (3) @(negedge clk);
        rst_an = 1'b1;
        repeat (20) @(negedge clk);
        check("no_beats_after_reset", load_cnt - base_load, 6);
        check("ready_after_reset", bus.cin_ready, 1);

        check("queues_empty", coef_q.size() + start_sig_q.size() + out_q.size(), 0);
        check("clear_pulses", clr_cnt, EXP_CLR);
        check("total_results", ov_cnt, 4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
